// File: rtl/ipq_pkg.sv
// ipq_pkg: shared types and default sizes for the instruction prefetch queue.
// Holds the FSM state encoding and the default AW/DW/DEPTH values.
package ipq_pkg;

    localparam int IPQ_AW    = 8;
    localparam int IPQ_DW    = 8;
    localparam int IPQ_DEPTH = 4;

    typedef enum logic [1:0] {
        IPQ_IDLE    = 2'd0,
        IPQ_REQ     = 2'd1,
        IPQ_DISCARD = 2'd2
    } ipq_state_e;

endpackage

// File: rtl/ip_prefetch_queue_if.sv
// ip_prefetch_queue_if: bundles the IP register controls, fetch bus, flush
// and decoder stream. master = prefetch stage, slave = its environment.
// out_addr exists only when IPQ_ADDR_TAG_EN is defined.
interface ip_prefetch_queue_if
    import ipq_pkg::*;
#(
    parameter int AW = IPQ_AW,
    parameter int DW = IPQ_DW
) ();

    logic [AW-1:0] ip_q;
    logic          ip_en;
    logic          ip_sel;
    logic [AW-1:0] ip_d;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_data;
    logic          flush;
    logic [AW-1:0] flush_addr;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
`ifdef IPQ_ADDR_TAG_EN
    logic [AW-1:0] out_addr;

    modport master (
        input  ip_q, mem_ack, mem_data, flush, flush_addr, out_ready,
        output ip_en, ip_sel, ip_d, mem_req, mem_addr,
        output out_valid, out_data, out_addr
    );

    modport slave (
        output ip_q, mem_ack, mem_data, flush, flush_addr, out_ready,
        input  ip_en, ip_sel, ip_d, mem_req, mem_addr,
        input  out_valid, out_data, out_addr
    );
`else
    modport master (
        input  ip_q, mem_ack, mem_data, flush, flush_addr, out_ready,
        output ip_en, ip_sel, ip_d, mem_req, mem_addr,
        output out_valid, out_data
    );

    modport slave (
        output ip_q, mem_ack, mem_data, flush, flush_addr, out_ready,
        input  ip_en, ip_sel, ip_d, mem_req, mem_addr,
        input  out_valid, out_data
    );
`endif

endinterface

// File: rtl/ipq_fifo.sv
// ipq_fifo: circular buffer with read/write pointers, occupancy count and a
// synchronous clear. Ports: i_clk, i_rst, i_clr, i_push/i_wdata, i_pop,
// o_rdata (head), o_count, o_full, o_empty. DEPTH must be a power of two.
module ipq_fifo #(
    parameter int DEPTH = 4,
    parameter int EW    = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic [EW-1:0]            i_wdata,
    input  logic                     i_pop,
    output logic [EW-1:0]            o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/ip_prefetch_queue.sv
// ip_prefetch_queue: fetches bytes at the current IP over a req/ack bus,
// queues them for the decoder and steers the IP register (increment on
// each completed fetch, load on flush). Ports: clk, rst, bus (master).
// Build option IPQ_ADDR_TAG_EN stores each byte's address and drives out_addr.
module ip_prefetch_queue
    import ipq_pkg::*;
#(
    parameter int DEPTH = IPQ_DEPTH,
    parameter int AW    = IPQ_AW,
    parameter int DW    = IPQ_DW
) (
    input  logic                clk,
    input  logic                rst,
    ip_prefetch_queue_if.master bus
);

`ifdef IPQ_ADDR_TAG_EN
    localparam int EW = AW + DW;
`else
    localparam int EW = DW;
`endif
    localparam int CW = $clog2(DEPTH) + 1;

    ipq_state_e    r_state;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_req;

    logic          w_ack_req;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [EW-1:0] w_wdata;
    logic [EW-1:0] w_rdata;
    logic [CW-1:0] w_count;

    assign w_ack_req = (r_state == IPQ_REQ) && bus.mem_ack;
    assign w_push    = w_ack_req && !bus.flush;
    assign w_pop     = !w_empty && bus.out_ready && !bus.flush;

    // A request is only issued with a free slot, so the ack push is always
    // accepted; flush stays in IDLE so the redirected IP is sampled next.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IPQ_IDLE;
            r_mem_addr <= '0;
            r_mem_req  <= 1'b0;
        end else begin
            unique case (r_state)
                IPQ_IDLE: begin
                    if (!bus.flush && !w_full) begin
                        r_mem_addr <= bus.ip_q;
                        r_mem_req  <= 1'b1;
                        r_state    <= IPQ_REQ;
                    end
                end
                IPQ_REQ: begin
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= IPQ_IDLE;
                    end else if (bus.flush) begin
                        r_state <= IPQ_DISCARD;
                    end
                end
                IPQ_DISCARD: begin
                    // The stale request must still complete; its data is dropped.
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= IPQ_IDLE;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= IPQ_IDLE;
                end
            endcase
        end
    end

    // Flush overrides the increment and is honoured in every state.
    assign bus.ip_en  = !rst && (bus.flush || w_ack_req);
    assign bus.ip_sel = !rst && bus.flush;
    assign bus.ip_d   = (!rst && bus.flush) ? bus.flush_addr : '0;

    assign bus.mem_req  = r_mem_req;
    assign bus.mem_addr = r_mem_addr;

`ifdef IPQ_ADDR_TAG_EN
    assign w_wdata      = {r_mem_addr, bus.mem_data};
    assign bus.out_addr = w_rdata[EW-1:DW];
`else
    assign w_wdata = bus.mem_data;
`endif
    assign bus.out_data  = w_rdata[DW-1:0];
    assign bus.out_valid = !w_empty;

    ipq_fifo #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (bus.flush),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_ip_prefetch_queue.sv
// tb_ip_prefetch_queue: directed bench with an IP register model and a
// one-cycle-latency memory returning {4'hA, addr[3:0]}.
module tb_ip_prefetch_queue;
    import ipq_pkg::*;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       mem_en    = 1'b1;
    logic       ip_ld     = 1'b1;
    logic [7:0] ip_ld_val = 8'h10;
    int         n_chk     = 0;
    int         n_pass    = 0;

    ip_prefetch_queue_if #(.AW(8), .DW(8)) bus ();

    ip_prefetch_queue #(
        .DEPTH (4),
        .AW    (8),
        .DW    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    always_comb bus.mem_data = {4'hA, bus.mem_addr[3:0]};

    always @(posedge clk) begin
        if (ip_ld)
            bus.ip_q <= ip_ld_val;
        else if (bus.ip_en)
            bus.ip_q <= bus.ip_sel ? bus.ip_d : bus.ip_q + 8'd1;
        if (rst)
            bus.mem_ack <= 1'b0;
        else
            bus.mem_ack <= mem_en & bus.mem_req & !bus.mem_ack;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_inc;
        int got;
        int cyc;
        bit first_req;

        bus.flush      = 1'b0;
        bus.flush_addr = '0;
        bus.out_ready  = 1'b0;
        tick;
        tick;

        chk("rst_req",   32'(bus.mem_req),   0);
        chk("rst_addr",  32'(bus.mem_addr),  0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_data",  32'(bus.out_data),  0);
        chk("rst_ip_en", 32'(bus.ip_en),     0);
        chk("rst_ipsel", 32'(bus.ip_sel),    0);
        chk("rst_ip_d",  32'(bus.ip_d),      0);
        chk("rst_count", 32'(dut.u_fifo.r_count), 0);
`ifdef IPQ_ADDR_TAG_EN
        chk("rst_oaddr", 32'(bus.out_addr), 0);
`endif
        rst   = 1'b0;
        ip_ld = 1'b0;

        // Fill: four fetches 0x10..0x13, one increment per ack.
        n_inc = 0;
        repeat (14) begin
            tick;
            if (bus.ip_en) begin
                chk("fill_sel",  32'(bus.ip_sel),   0);
                chk("fill_addr", 32'(bus.mem_addr), 32'('h10 + n_inc));
                n_inc++;
            end
        end
        chk("fill_incs",  32'(n_inc), 4);
        chk("fill_count", 32'(dut.u_fifo.r_count), 4);
        chk("fill_head",  32'(bus.out_data), 'hA0);
        chk("fill_ipq",   32'(bus.ip_q), 'h14);
`ifdef IPQ_ADDR_TAG_EN
        chk("fill_oaddr", 32'(bus.out_addr), 'h10);
`endif
        tick;
        chk("fill_noreq", 32'(bus.mem_req), 0);

        // Drain with refetch starting once a slot frees.
        bus.out_ready = 1'b1;
        got = 0;
        first_req = 1'b1;
        for (int c = 0; c < 30 && got < 5; c++) begin
            if (bus.out_valid) begin
                chk("drain_data", 32'(bus.out_data), 32'('hA0 + got));
`ifdef IPQ_ADDR_TAG_EN
                chk("drain_oaddr", 32'(bus.out_addr), 32'('h10 + got));
`endif
                got++;
            end
            if (bus.mem_req && first_req) begin
                chk("refetch_addr", 32'(bus.mem_addr), 'h14);
                first_req = 1'b0;
            end
            tick;
        end
        chk("drain_cnt", 32'(got), 5);

        // Refill to 0x15..0x18, then free one slot with acks disabled.
        bus.out_ready = 1'b0;
        repeat (16) tick;
        chk("refill_count", 32'(dut.u_fifo.r_count), 4);
        mem_en = 1'b0;
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 6 && !bus.mem_req; c++) tick;
        tick;
        chk("stall_req",  32'(bus.mem_req),  1);
        chk("stall_addr", 32'(bus.mem_addr), 'h19);
        chk("stall_head", 32'(bus.out_data), 'hA6);

        // Flush in REQ without ack.
        bus.flush      = 1'b1;
        bus.flush_addr = 8'h40;
        #1;
        chk("fl_ip_en", 32'(bus.ip_en),  1);
        chk("fl_ipsel", 32'(bus.ip_sel), 1);
        chk("fl_ip_d",  32'(bus.ip_d),   'h40);
        tick;
        bus.flush = 1'b0;
        #1;
        chk("fl_state", 32'(dut.r_state),   32'(IPQ_DISCARD));
        chk("fl_valid", 32'(bus.out_valid), 0);
        chk("fl_hold",  32'(bus.mem_addr),  'h19);
        chk("fl_req",   32'(bus.mem_req),   1);
        chk("fl_ipq",   32'(bus.ip_q),      'h40);
        chk("fl_ip_d0", 32'(bus.ip_d),      0);
        mem_en = 1'b1;
        tick;
        chk("disc_ack",    32'(bus.mem_ack), 1);
        chk("disc_no_inc", 32'(bus.ip_en),   0);
        tick;
        chk("disc_drop",  32'(bus.out_valid), 0);
        chk("disc_idle",  32'(dut.r_state),   32'(IPQ_IDLE));
        tick;
        chk("redir_req",  32'(bus.mem_req),  1);
        chk("redir_addr", 32'(bus.mem_addr), 'h40);
        tick;

        // Flush coincident with the ack: byte dropped, load wins.
        chk("co_ack", 32'(bus.mem_ack), 1);
        bus.flush      = 1'b1;
        bus.flush_addr = 8'h80;
        #1;
        chk("co_ip_en", 32'(bus.ip_en),  1);
        chk("co_ipsel", 32'(bus.ip_sel), 1);
        chk("co_ip_d",  32'(bus.ip_d),   'h80);
        tick;
        bus.flush = 1'b0;
        chk("co_valid", 32'(bus.out_valid), 0);
        chk("co_state", 32'(dut.r_state),   32'(IPQ_IDLE));
        chk("co_ipq",   32'(bus.ip_q),      'h80);
        tick;
        chk("co_addr", 32'(bus.mem_addr), 'h80);
        chk("co_req",  32'(bus.mem_req),  1);

        // Reset mid-REQ, IP reloaded to 0xFF.
        rst       = 1'b1;
        ip_ld     = 1'b1;
        ip_ld_val = 8'hFF;
        tick;
        rst   = 1'b0;
        ip_ld = 1'b0;
        chk("mr_req",   32'(bus.mem_req),   0);
        chk("mr_valid", 32'(bus.out_valid), 0);
        chk("mr_count", 32'(dut.u_fifo.r_count), 0);

        // Wrap 0xFF -> 0x00 with no stall.
        bus.out_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (cyc < 12 && got < 2) begin
            if (bus.out_valid) begin
                chk("wrap_data", 32'(bus.out_data), (got == 0) ? 'hAF : 'hA0);
`ifdef IPQ_ADDR_TAG_EN
                chk("wrap_oaddr", 32'(bus.out_addr), (got == 0) ? 'hFF : 'h00);
`endif
                got++;
            end
            tick;
            cyc++;
        end
        chk("wrap_cnt", 32'(got), 2);
        chk("wrap_lat", 32'(cyc), 7);
        chk("wrap_ipq", 32'(bus.ip_q), 'h01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
